// File: rtl/commit_sequencer_pkg.sv
// Shared types for the ROB commit path: head-entry layout, commit classes and
// sequencer states.
package commit_sequencer_pkg;

    localparam int XLEN            = 64;
    localparam int ROB_IDX_LEN     = 4;
    localparam int EXCEPT_CODE_LEN = 5;

    typedef enum logic [1:0] {
        COMM_INT,
        COMM_STORE,
        COMM_JUMP,
        COMM_OTHER
    } comm_type_t;

    typedef struct packed {
        comm_type_t                 comm_type;
        logic                       rd_upd;
        logic [4:0]                 rd_idx;
        logic [XLEN-1:0]            instr_pc;
        logic [XLEN-1:0]            target_pc;
        logic [XLEN-1:0]            res_value;
        logic                       res_ready;
        logic                       except_raised;
        logic [EXCEPT_CODE_LEN-1:0] except_code;
        logic                       mispredicted;
    } rob_entry_t;

    typedef enum logic {
        S_RUN,
        S_FLUSH
    } commit_state_t;

    // x0 is hardwired, so an update targeting it must not touch RF or status
    function automatic logic writes_rd(rob_entry_t e);
        return e.rd_upd && (e.rd_idx != 5'd0);
    endfunction

endpackage

// File: rtl/commit_sequencer.sv
// Retires ROB head entries in program order: RF write, status clear, store
// release, trap/redirect with a one-cycle flush, and the instret counter.
module commit_sequencer
    import commit_sequencer_pkg::*;
#(
    parameter int XLEN        = commit_sequencer_pkg::XLEN,
    parameter int ROB_IDX_LEN = commit_sequencer_pkg::ROB_IDX_LEN
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       comm_valid_i,
    output logic                       comm_ready_o,
    input  rob_entry_t                 comm_data_i,
    input  logic [ROB_IDX_LEN-1:0]     comm_head_idx_i,
    output logic                       rf_we_o,
    output logic [4:0]                 rf_addr_o,
    output logic [XLEN-1:0]            rf_data_o,
    output logic                       rs_clr_valid_o,
    output logic [4:0]                 rs_clr_addr_o,
    output logic [ROB_IDX_LEN-1:0]     rs_clr_rob_idx_o,
    output logic                       sb_valid_o,
    input  logic                       sb_ready_i,
    output logic                       flush_o,
    output logic                       redirect_valid_o,
    output logic [XLEN-1:0]            redirect_pc_o,
    output logic                       trap_valid_o,
    output logic [EXCEPT_CODE_LEN-1:0] trap_cause_o,
    output logic [XLEN-1:0]            trap_pc_o,
    output logic [63:0]                instret_o
);

    commit_state_t              state_q, state_d;
    logic                       rf_we_q, rf_we_d;
    logic [4:0]                 rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]            rf_data_q, rf_data_d;
    logic                       rs_clr_valid_q, rs_clr_valid_d;
    logic [4:0]                 rs_clr_addr_q, rs_clr_addr_d;
    logic [ROB_IDX_LEN-1:0]     rs_clr_rob_idx_q, rs_clr_rob_idx_d;
    logic                       redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]            redirect_pc_q, redirect_pc_d;
    logic                       trap_valid_q, trap_valid_d;
    logic [EXCEPT_CODE_LEN-1:0] trap_cause_q, trap_cause_d;
    logic [XLEN-1:0]            trap_pc_q, trap_pc_d;
    logic [63:0]                instret_q, instret_d;

    // The ROB only raises valid once the result is ready
    logic unusedResReady;
    assign unusedResReady = comm_data_i.res_ready;

    always_comb begin
        state_d          = state_q;
        comm_ready_o     = 1'b0;
        sb_valid_o       = 1'b0;
        rf_we_d          = 1'b0;
        rf_addr_d        = '0;
        rf_data_d        = '0;
        rs_clr_valid_d   = 1'b0;
        rs_clr_addr_d    = '0;
        rs_clr_rob_idx_d = '0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        trap_valid_d     = 1'b0;
        trap_cause_d     = '0;
        trap_pc_d        = '0;
        instret_d        = instret_q;

        case (state_q)
            S_RUN: begin
                if (comm_valid_i) begin
                    if (comm_data_i.except_raised) begin
                        comm_ready_o = 1'b1;
                        trap_valid_d = 1'b1;
                        trap_cause_d = comm_data_i.except_code;
                        trap_pc_d    = comm_data_i.instr_pc;
                        state_d      = S_FLUSH;
                    end else if (comm_data_i.comm_type == COMM_STORE) begin
                        // Store waits at the head until the store buffer takes it
                        sb_valid_o   = 1'b1;
                        comm_ready_o = sb_ready_i;
                        if (sb_ready_i) begin
                            instret_d = instret_q + 64'd1;
                        end
                    end else begin
                        comm_ready_o = 1'b1;
                        instret_d    = instret_q + 64'd1;
                        if (writes_rd(comm_data_i)) begin
                            rf_we_d          = 1'b1;
                            rf_addr_d        = comm_data_i.rd_idx;
                            rf_data_d        = comm_data_i.res_value;
                            rs_clr_valid_d   = 1'b1;
                            rs_clr_addr_d    = comm_data_i.rd_idx;
                            rs_clr_rob_idx_d = comm_head_idx_i;
                        end
                        if (comm_data_i.comm_type == COMM_JUMP && comm_data_i.mispredicted) begin
                            redirect_valid_d = 1'b1;
                            redirect_pc_d    = comm_data_i.target_pc;
                            state_d          = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_RUN;
            rf_we_q          <= 1'b0;
            rf_addr_q        <= '0;
            rf_data_q        <= '0;
            rs_clr_valid_q   <= 1'b0;
            rs_clr_addr_q    <= '0;
            rs_clr_rob_idx_q <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            trap_valid_q     <= 1'b0;
            trap_cause_q     <= '0;
            trap_pc_q        <= '0;
            instret_q        <= '0;
        end else begin
            state_q          <= state_d;
            rf_we_q          <= rf_we_d;
            rf_addr_q        <= rf_addr_d;
            rf_data_q        <= rf_data_d;
            rs_clr_valid_q   <= rs_clr_valid_d;
            rs_clr_addr_q    <= rs_clr_addr_d;
            rs_clr_rob_idx_q <= rs_clr_rob_idx_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            trap_valid_q     <= trap_valid_d;
            trap_cause_q     <= trap_cause_d;
            trap_pc_q        <= trap_pc_d;
            instret_q        <= instret_d;
        end
    end

    assign flush_o          = (state_q == S_FLUSH);
    assign rf_we_o          = rf_we_q;
    assign rf_addr_o        = rf_addr_q;
    assign rf_data_o        = rf_data_q;
    assign rs_clr_valid_o   = rs_clr_valid_q;
    assign rs_clr_addr_o    = rs_clr_addr_q;
    assign rs_clr_rob_idx_o = rs_clr_rob_idx_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign trap_valid_o     = trap_valid_q;
    assign trap_cause_o     = trap_cause_q;
    assign trap_pc_o        = trap_pc_q;
    assign instret_o        = instret_q;

endmodule

// File: doc/commit_sequencer.md
Name: commit_sequencer

Overview:
Consumer end of the ROB commit interface. It pops completed entries from the ROB head in program order and retires them: integer register-file write, register-status clear, and store release to the store buffer. It detects exceptions and mispredicted jumps, raises a one-cycle pipeline flush, and emits trap or redirect information. It also maintains the 64-bit instret counter. It sits between the ROB and the register file, register-status unit, store buffer and front-end.

Parameters:
XLEN, len5_pkg::XLEN (64), data and PC width
ROB_IDX_LEN, expipe_pkg::ROB_IDX_LEN, ROB index width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock, synchronous, active-high
comm_valid_i  in  1  ROB head entry valid and result ready
comm_ready_o  out  1  pop ROB head
comm_data_i  in  rob_entry_t  ROB head entry
comm_head_idx_i  in  ROB_IDX_LEN  ROB head index
rf_we_o  out  1  integer register-file write enable
rf_addr_o  out  5  destination register
rf_data_o  out  XLEN  write data
rs_clr_valid_o  out  1  register-status clear request
rs_clr_addr_o  out  5  register to clear
rs_clr_rob_idx_o  out  ROB_IDX_LEN  clear only if status still points to this index
sb_valid_o  out  1  release head store to store buffer
sb_ready_i  in  1  store buffer accepts release
flush_o  out  1  pipeline flush (ROB, issue, RS, front-end)
redirect_valid_o  out  1  front-end redirect
redirect_pc_o  out  XLEN  redirect target
trap_valid_o  out  1  exception taken
trap_cause_o  out  EXCEPT_CODE_LEN  exception code
trap_pc_o  out  XLEN  faulting PC
instret_o  out  64  retired-instruction count

Behaviour:
- FSM states: S_RUN (reset state) and S_FLUSH.
- Reset (rst_i=1 at a clock edge, including mid-operation): state goes to S_RUN; all registered outputs go to 0; instret_o=0. With state S_RUN and comm_valid_i low, comm_ready_o and sb_valid_o are also 0.
- Pop at cycle T means comm_valid_i && comm_ready_o. All retire effects are registered and visible at T+1 for exactly one cycle:
  - rf_*
  - rs_clr_*
  - redirect_*
  - trap_*
  - flush_o
  - instret increment
- S_RUN, comm_valid_i=1, selection by priority:
  1. except_raised=1: comm_ready_o=1, no register write, no status clear, no instret increment. At T+1: trap_valid_o=1, trap_cause_o=except_code, trap_pc_o=instr_pc. Next state is S_FLUSH.
  2. comm_type==COMM_STORE: sb_valid_o=1 (combinational); comm_ready_o=sb_ready_i. If sb_ready_i=0, hold the entry: no pop, no side effects, stay in S_RUN. On pop, instret is incremented.
  3. comm_type==COMM_JUMP with mispredicted=1: comm_ready_o=1. Register write as in item 4. At T+1: redirect_valid_o=1, redirect_pc_o=target_pc. Next state is S_FLUSH.
  4. Otherwise: comm_ready_o=1, instret is incremented. If rd_upd=1 and rd_idx!=0, then at T+1: rf_we_o=1, rf_addr_o=rd_idx, rf_data_o=res_value, rs_clr_valid_o=1, rs_clr_rob_idx_o=comm_head_idx_i.
- rd_idx=0: neither rf_we_o nor rs_clr_valid_o is asserted.
- S_FLUSH: flush_o=1 (Moore output), comm_ready_o=0, sb_valid_o=0. Next state is always S_RUN. A mispredicted jump produces rf write, rs clear and flush in the same cycle; downstream units must honour all three.
- Throughput: one retire per cycle in S_RUN. There is no pop during S_FLUSH, so an exception or mispredict costs one bubble.
- instret_o wraps from 2^64-1 to 0 silently.
- comm_ready_o never depends on comm_ready-style feedback from outputs other than sb_ready_i, so there are no combinational loops with the ROB.

Decomposition:
- expipe_pkg additions:
  - comm_type_t enum {COMM_INT, COMM_STORE, COMM_JUMP, COMM_OTHER}
  - rob_entry_t fields comm_type, rd_upd, rd_idx, instr_pc, target_pc, mispredicted (res_value, res_ready, except_raised and except_code already exist)
  - commit_state_t enum {S_RUN, S_FLUSH}
- No sub-module required. The instret counter is an inline 64-bit register. An optional commit_decoder sub-module holds the combinational priority decode.

Test Plan:
- Reset mid-flush: rst_i=1 while state=S_FLUSH -> next cycle flush_o=0, instret_o=0, state S_RUN.
- Three back-to-back COMM_INT entries:
  - Entries: rd=5, value 0x11, rob idx 0; rd=6, value 0x22, idx 1; rd=0, idx 2.
  - Required: three pops in three consecutive cycles.
  - Required: rf_we_o pulses at T+1 and T+2 with the matching addr/data.
  - Required: no write for rd=0.
  - Required: instret_o=3.
- Store with sb_ready_i=0 for 4 cycles, then 1 -> sb_valid_o held high, comm_ready_o=0 for 4 cycles, a single pop in cycle 5, instret_o +1.
- Exception entry (except_code=2, instr_pc=0x8000_0010) -> T+1: trap_valid_o=1, trap_cause_o=2, trap_pc_o=0x8000_0010, flush_o=1, rf_we_o=0, instret unchanged. T+2: comm_ready_o resumes.
- Mispredicted jump (rd=1, link 0x104, target_pc 0x200) -> T+1: rf_we_o=1 with rf_addr_o=1 and rf_data_o=0x104, redirect_valid_o=1 with redirect_pc_o=0x200, flush_o=1. The following valid entry is not popped at T+1.
- instret preloaded via force to 2^64-1, then one INT retire -> instret_o=0.
